// File: rtl/aes_kexp_seq.sv
// aes_kexp_seq: sequential AES key-schedule engine and round-key server.
//
// Expands a 128/192/256-bit cipher key (NK = 4/6/8 words) into W = 4*(NK+7)
// 32-bit words, one word per clock, through a single external 4-byte S-box
// port. Round keys are served from the internal word buffer.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start           begin expansion (honoured in IDLE/DONE only)
//   key[255:0]      cipher key, byte 0 at [255:248], upper 32*NK bits used
//   sbox_idx/val    shared S-box lookup, byte-wise, same-cycle result
//   busy / ready    LOAD/EXPAND in progress / buffer complete
//   rk_req, rk_round  round-key read request
//   rk_valid, rk_data, rk_err  one-cycle response, 1-cycle latency
//
// Build option: AES_KEXP_ZEROIZE_EN -- buffer resets to zero, LOAD clears
// the derived words, and rk_data is wiped the cycle after each delivery.
module aes_kexp_seq #(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    output logic [31:0]  sbox_idx,
    input  logic [31:0]  sbox_val,
    output logic         busy,
    output logic         ready,
    input  logic         rk_req,
    input  logic [3:0]   rk_round,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic         rk_err
);
    localparam int NR = NK + 6;
    localparam int W  = 4 * (NR + 1);
    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   i;
    logic [2:0]      j;
    logic [7:0]      rcon;
    logic [31:0]     wbuf [W];

    logic [IW-1:0]   prev_idx, back_idx, rbase;
    logic [31:0]     prev, rot, temp, nw;
    logic            accept;

    if (NK < 8) begin : g_key_tail
        logic unused_key;
        assign unused_key = ^key[255-32*NK:0];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        ready    = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   begin busy = 1'b1; state_nx = S_EXPAND; end
            S_EXPAND: begin
                busy = 1'b1;
                if (i == IW'(W - 1)) state_nx = S_DONE;
            end
            S_DONE:   begin ready = 1'b1; if (start) state_nx = S_LOAD; end
            default:  state_nx = S_IDLE;
        endcase
    end

    // ---------------- word datapath ----------------
    // Critical path: w[i-1] -> S-box (external) -> xor with w[i-NK] -> w[i].
    always_comb begin
        prev_idx = i - IW'(1);
        back_idx = i - IW'(NK);
        prev     = wbuf[prev_idx];
        rot      = {prev[23:0], prev[31:24]};
        sbox_idx = 32'h0;
        if (state == S_EXPAND) sbox_idx = (j == 3'd0) ? rot : prev;
        temp = prev;
        if (j == 3'd0)                    temp = sbox_val ^ {rcon, 24'h0};
        else if ((NK == 8) && (j == 3'd4)) temp = sbox_val;
        nw = wbuf[back_idx] ^ temp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i    <= '0;
            j    <= '0;
            rcon <= '0;
        end else if (state == S_LOAD) begin
            i    <= IW'(NK);
            j    <= '0;
            rcon <= 8'h01;
        end else if (state == S_EXPAND) begin
            i <= i + IW'(1);
            j <= (j == 3'(NK - 1)) ? 3'd0 : j + 3'd1;
            if (j == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

`ifdef AES_KEXP_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < W; k++) wbuf[k] <= '0;
        end else
`else
    always_ff @(posedge clk) begin
`endif
        if (state == S_LOAD) begin
            for (int k = 0; k < NK; k++) wbuf[k] <= key[255-32*k -: 32];
`ifdef AES_KEXP_ZEROIZE_EN
            for (int k = NK; k < W; k++) wbuf[k] <= '0;
`endif
        end else if (state == S_EXPAND) begin
            wbuf[i] <= nw;
        end
    end

    // ---------------- read port ----------------
    // A start in the same DONE cycle wins: the buffer is about to be rebuilt.
    assign accept = rk_req && (state == S_DONE) && !start;
    assign rbase  = IW'({rk_round, 2'b00});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
            rk_data  <= '0;
        end else begin
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
`ifdef AES_KEXP_ZEROIZE_EN
            if (rk_valid) rk_data <= '0;
`endif
            if (accept) begin
                if (rk_round <= 4'(NR)) begin
                    rk_valid <= 1'b1;
                    rk_data  <= {wbuf[rbase], wbuf[rbase + IW'(1)],
                                 wbuf[rbase + IW'(2)], wbuf[rbase + IW'(3)]};
                end else begin
                    rk_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_kexp_seq.sv
// Directed bench for aes_kexp_seq: one instance per key size sharing control,
// an S-box built from GF(2^8) arithmetic, FIPS-197 expected round keys.
module tb_aes_kexp_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         start, rk_req;
    logic [3:0]   rk_round;
    logic [255:0] key4, key6, key8;
    logic [31:0]  sidx4, sidx6, sidx8, sval4, sval6, sval8;
    logic         busy4, busy6, busy8, ready4, ready6, ready8;
    logic         v4, v6, v8, e4, e6, e8;
    logic [127:0] d4, d6, d8;
    logic [7:0]   sb [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] sbw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction
    assign sval4 = sbw(sidx4);
    assign sval6 = sbw(sidx6);
    assign sval8 = sbw(sidx8);

    aes_kexp_seq #(.NK(4)) u4 (.clk(clk), .rst(rst), .start(start), .key(key4),
        .sbox_idx(sidx4), .sbox_val(sval4), .busy(busy4), .ready(ready4),
        .rk_req(rk_req), .rk_round(rk_round), .rk_valid(v4), .rk_data(d4), .rk_err(e4));
    aes_kexp_seq #(.NK(6)) u6 (.clk(clk), .rst(rst), .start(start), .key(key6),
        .sbox_idx(sidx6), .sbox_val(sval6), .busy(busy6), .ready(ready6),
        .rk_req(rk_req), .rk_round(rk_round), .rk_valid(v6), .rk_data(d6), .rk_err(e6));
    aes_kexp_seq #(.NK(8)) u8 (.clk(clk), .rst(rst), .start(start), .key(key8),
        .sbox_idx(sidx8), .sbox_val(sval8), .busy(busy8), .ready(ready8),
        .rk_req(rk_req), .rk_round(rk_round), .rk_valid(v8), .rk_data(d8), .rk_err(e8));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h0; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: plain; 1: rk_req held and start re-pulsed while busy;
    // 2: start coincides with rk_req in DONE.
    task automatic expand(input int mode);
        int t4, t6, t8;
        bit both, vbusy;
        t4 = 0; t6 = 0; t8 = 0; both = 0; vbusy = 0;
        @(negedge clk);
        start = 1'b1;
        if (mode == 2) begin rk_req = 1'b1; rk_round = 4'd1; end
        @(posedge clk); #1;
        chk("busy_after_start", busy4, 1);
        chk("ready_after_start", ready4, 0);
        if (mode == 2) chk("req_with_start_dropped", v4, 0);
        start    = 1'b0;
        rk_req   = (mode == 1);
        rk_round = 4'd1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (ready4 && t4 == 0) t4 = n;
            if (ready6 && t6 == 0) t6 = n;
            if (ready8 && t8 == 0) t8 = n;
            if ((busy4 && ready4) || (busy6 && ready6) || (busy8 && ready8)) both = 1;
            if (mode == 1) begin
                if (v4 || e4) vbusy = 1;
                start = (n == 10);
                if (n == 40) rk_req = 1'b0;
            end
        end
        chk($sformatf("ready_cycle_nk4_m%0d", mode), t4, 41);
        chk($sformatf("ready_cycle_nk6_m%0d", mode), t6, 47);
        chk($sformatf("ready_cycle_nk8_m%0d", mode), t8, 53);
        chk("busy_ready_exclusive", both, 0);
        if (mode == 1) chk("no_valid_while_busy", vbusy, 0);
    endtask

    task automatic rd(input logic [3:0] r);
        @(negedge clk);
        rk_req = 1'b1; rk_round = r;
        @(posedge clk); #1;
        rk_req = 1'b0;
    endtask

    typedef struct {
        int         sel;
        logic [3:0] rnd;
        bit         err;
        logic [127:0] exp;
    } vec_t;
    vec_t tv [14];

    localparam logic [127:0] R4_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R4_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v, e;
        logic [127:0] d;
        tv[0]  = '{4, 4'd0,  0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        tv[1]  = '{4, 4'd1,  0, R4_1};
        tv[2]  = '{4, 4'd2,  0, 128'hf2c295f27a96b9435935807a7359f67f};
        tv[3]  = '{4, 4'd9,  0, 128'hac7766f319fadc2128d12941575c006e};
        tv[4]  = '{4, 4'd10, 0, R4_10};
        tv[5]  = '{4, 4'd11, 1, 128'h0};
        tv[6]  = '{6, 4'd0,  0, 128'h8e73b0f7da0e6452c810f32b809079e5};
        tv[7]  = '{6, 4'd1,  0, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        tv[8]  = '{6, 4'd12, 0, 128'he98ba06f448c773c8ecc720401002202};
        tv[9]  = '{6, 4'd13, 1, 128'h0};
        tv[10] = '{8, 4'd1,  0, 128'h1f352c073b6108d72d9810a30914dff4};
        tv[11] = '{8, 4'd2,  0, 128'h9ba354118e6925afa51a8b5f2067fcde};
        tv[12] = '{8, 4'd14, 0, 128'hfe4890d1e6188d0b046df344706c631e};
        tv[13] = '{8, 4'd15, 1, 128'h0};

        build_sbox();
        key4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        key6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        key8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        rst = 1'b0; start = 1'b0; rk_req = 1'b0; rk_round = 4'd0;
        #12;
        chk("reset_busy", busy4, 0);
        chk("reset_ready", ready4, 0);
        chk("reset_rk_valid", v4, 0);
        chk("reset_rk_err", e4, 0);
        chk("reset_rk_data", d4, 0);
        chk("reset_sbox_idx", sidx4, 0);
        @(negedge clk); rst = 1'b1;

        expand(0);

        foreach (tv[k]) begin
            rd(tv[k].rnd);
            case (tv[k].sel)
                4:       begin v = v4; e = e4; d = d4; end
                6:       begin v = v6; e = e6; d = d6; end
                default: begin v = v8; e = e8; d = d8; end
            endcase
            chk($sformatf("nk%0d_r%0d_err", tv[k].sel, tv[k].rnd), e, tv[k].err);
            chk($sformatf("nk%0d_r%0d_valid", tv[k].sel, tv[k].rnd), v, !tv[k].err);
            if (!tv[k].err) chk($sformatf("nk%0d_r%0d_data", tv[k].sel, tv[k].rnd), d, tv[k].exp);
        end

        // back-to-back requests, then pulse clears and data hold/wipe
        @(negedge clk); rk_req = 1'b1; rk_round = 4'd1;
        @(posedge clk); #1;
        chk("b2b_first_valid", v4, 1);
        chk("b2b_first_data", d4, R4_1);
        rk_round = 4'd10;
        @(posedge clk); #1;
        chk("b2b_second_valid", v4, 1);
        chk("b2b_second_data", d4, R4_10);
        rk_req = 1'b0;
        @(posedge clk); #1;
        chk("valid_clears", v4, 0);
`ifdef AES_KEXP_ZEROIZE_EN
        chk("data_wiped_after_valid", d4, 0);
`else
        chk("data_held_after_valid", d4, R4_10);
`endif
        rd(4'd11);
        @(posedge clk); #1;
        chk("err_clears", e4, 0);

        expand(1);
        rd(4'd10);
        chk("after_mid_start_r10", d4, R4_10);

        expand(2);
        rd(4'd1);
        chk("after_start_req_r1", d4, R4_1);

        // reset in the middle of expansion
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (20) @(posedge clk);
        #1; rst = 1'b0; #1;
        chk("midreset_busy", busy4, 0);
        chk("midreset_ready", ready4, 0);
        chk("midreset_rk_data", d4, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_stays_idle", ready4, 0);
        expand(0);
        rd(4'd10);
        chk("post_reset_r10_valid", v4, 1);
        chk("post_reset_r10_data", d4, R4_10);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes_kexp_seq.md
# aes_kexp_seq

Sequential AES key-schedule engine and round-key server. It expands a 128/192/256-bit cipher key into Nb*(Nr+1) 32-bit words, one word per clock, using a single shared 4-byte S-box lookup port to the S-box table. It stores the words in an internal buffer and hands out 128-bit round keys to the cipher core through a request/valid read port. It replaces the fully combinational key expansion in the datapath, trading area for latency.

## Interface
- NK, default 4: key length in 32-bit words, legal values 4/6/8. Nb=4 and Nr=NK+6 are fixed; W=4*(Nr+1), giving 44/52/60 words.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin expansion; sampled only in IDLE or DONE.
- key  in  256  cipher key, byte 0 at [255:248]; only the upper 32*NK bits are used. Sampled on the LOAD edge.
- sbox_idx  out  32  four S-box indices, byte-wise; combinational from state.
- sbox_val  in  32  S-box results for sbox_idx, byte-wise, combinational, same cycle.
- busy  out  1  high in LOAD and EXPAND.
- ready  out  1  high in DONE; the buffer is complete.
- rk_req  in  1  round-key read request.
- rk_round  in  4  requested round, 0..Nr.
- rk_valid  out  1  one-cycle pulse: rk_data is valid.
- rk_data  out  128  round key; w[4r] at [127:96] through w[4r+3] at [31:0].
- rk_err  out  1  one-cycle pulse: the accepted request had rk_round > Nr.

## Operation
- FSM: IDLE -> LOAD -> EXPAND -> DONE.
  - IDLE: start=1 -> LOAD.
  - LOAD: w[0..NK-1] <= key words. Set i=NK, j=0 (i mod NK), rcon=8'h01. -> EXPAND.
  - EXPAND: each cycle, temp=w[i-1].
    - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon) (shift left; XOR 8'h1b on carry-out).
    - Else if NK==8 and j==4: temp = SubWord(temp).
    - Write w[i] = w[i-NK] ^ temp; i++; j wraps at NK.
    - After writing w[W-1] -> DONE.
  - DONE: start=1 -> LOAD. This restarts expansion and drops ready.
- sbox_idx = RotWord(w[i-1]) when j==0, else w[i-1]. In states other than EXPAND it is driven 0, and the sbox_val result is unused.
- start during LOAD/EXPAND: ignored.
- Read port:
  - rk_req is accepted only when ready=1 and the FSM stays in DONE that cycle, i.e. not a simultaneous start.
  - Otherwise the request is dropped: no rk_valid, no rk_err.
  - Accepted request with rk_round <= Nr: rk_valid=1 next cycle with rk_data = w[4r..4r+3].
  - Accepted request with rk_round > Nr: rk_err=1 next cycle, rk_valid=0, rk_data unchanged.
  - Back-to-back requests are accepted every cycle.
- Reset values: state IDLE; busy, ready, rk_valid and rk_err all 0; rk_data 0; i, j, rcon 0.
- Reset mid-expansion: returns to IDLE at once; a partial buffer is never flagged ready.

## Timing
- start sampled at edge E0, LOAD at E1; w[i] is written at edge E1+(i-NK+1).
- ready rises after edge E0+(W-NK)+1: 41 cycles for NK=4, 47 for NK=6, 53 for NK=8.
- busy is high from after E0 until ready rises. busy and ready are never both 1.
- Read latency is 1 cycle: request at edge R, rk_valid high after R and cleared after R+1 unless re-requested.
- The S-box path is combinational from w[i-1] to w[i] within one cycle; this is the critical path.

## Configuration
- AES_KEXP_ZEROIZE_EN defined:
  - The word buffer is asynchronously reset to zero.
  - LOAD clears w[NK..W-1] to zero in the same edge.
  - rk_data returns to 0 the cycle after every rk_valid pulse.
- Not defined:
  - The buffer has no reset, and stale words persist until overwritten.
  - rk_data holds the last delivered key.

## Test plan
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, start -> ready after 41 cycles. Read round 1 -> a0fafe1788542cb123a339392a6c7605. Read round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> ready after 47 cycles; round 12 word 3 (w[51]) = 01002202.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> ready after 53 cycles; w[59] = 706c631e.
- Protocol (NK=4):
  - rk_req during busy -> no rk_valid.
  - rk_round=11 in DONE -> rk_err pulse, rk_valid 0.
  - start mid-EXPAND -> ignored; ready still at cycle 41.
  - start and rk_req in the same DONE cycle -> request dropped, LOAD entered.
- Reset asserted at expansion cycle 20 -> busy/ready 0 immediately; a new start yields a correct round 10 key after 41 cycles.
- With AES_KEXP_ZEROIZE_EN: after reset, rk_data=0, and rk_data reads 0 on the cycle after each valid pulse.
